writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port StallW  input  1  hold the W register contents.
REQ-005 SHALL have port FlushW  input  1  insert a bubble into W.
REQ-006 SHALL have port ValidM  input  1  M-stage slot holds a real instruction.
REQ-007 SHALL have port RegWriteM  input  1  instruction writes rd.
REQ-008 SHALL have port ResultSrcM  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-009 SHALL have port LoadTypeM  input  3  load funct3 code.
REQ-010 SHALL have port ALUResultM  input  WIDTH  ALU result or effective address.
REQ-011 SHALL have port ReadDataM  input  WIDTH  raw data-memory word.
REQ-012 SHALL have port PCPlus4M  input  WIDTH  return address.
REQ-013 SHALL have port RdM  input  5  destination register.
REQ-014 SHALL have port RegWriteW  output  1  register-file write enable.
REQ-015 SHALL have port RdW  output  5  register-file write address.
REQ-016 SHALL have port ResultW  output  WIDTH  write data, also the forwarding source.
REQ-017 SHALL have port ValidW  output  1  W slot holds a real instruction.
REQ-018 SHALL have port MisalignW  output  1  misaligned load in W.

Function
REQ-019 SHALL register all M inputs on the rising clk edge, giving 1-cycle latency from M to W.
REQ-020 SHALL resolve a clock edge with priority: reset, then FlushW, then StallW, then load.
REQ-021 SHALL, on FlushW, clear ValidW and the registered RegWrite and retain the other fields (don't-care); FlushW SHALL override StallW.
REQ-022 SHALL, on StallW without FlushW, hold every register unchanged.
REQ-023 SHALL drive RegWriteW = reg RegWrite & ValidW & (RdW != 0) & !MisalignW.
REQ-024 SHALL drive ResultW combinationally from the registered fields: 00 ALU, 01 extended load, 10 PC+4, 11 ALU.
REQ-025 SHALL select the byte lane with ALUResult[1:0] and the halfword with ALUResult[1].
REQ-026 SHALL extend loads per funct3: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero, any other code as LW.
REQ-027 SHALL assert MisalignW when ValidW, ResultSrc = 01, and either (LH/LHU with addr[0] = 1) or (LW with addr[1:0] != 0); ResultW is then 0.
REQ-028 SHALL never assert MisalignW for a non-load or a bubble.

Reset
REQ-029 SHALL, on a clk edge with rst = 0, clear every register: ValidW 0, RegWriteW 0, RdW 0, ResultW 0, MisalignW 0, counter 0.
REQ-030 SHALL let reset mid-stall discard the held instruction, with no write issued on or after that edge.

Configuration
REQ-031 SHALL, with macro WRITEBACK_RETIRE_CNT_EN defined, add output RetireCountW (32 bits), incremented on each edge where ValidW = 1 and StallW = 0, wrapping 0xFFFFFFFF -> 0.
REQ-032 SHALL count misaligned instructions as retired.
REQ-033 SHALL, without the macro, have no RetireCountW port and no counter logic.

Structure
REQ-034 SHALL take result_src and load_type enums and the funct3 constants from shared package pipeline_pkg.
REQ-035 SHALL implement lane select, extension and misalignment in combinational sub-module load_extend; the top holds the registers, mux and counter.

Verification
REQ-036 SHALL test LB: ALUResultM 0x1003, ReadDataM 0x80FF_1234, RdM 5 -> next cycle ResultW 0xFFFF_FF80, RegWriteW 1, RdW 5.
REQ-037 SHALL test LHU: addr 0x2002, data 0xBEEF_0000 -> ResultW 0x0000_BEEF; LH addr 0x2001 -> MisalignW 1, RegWriteW 0, ResultW 0.
REQ-038 SHALL test a write to x0: ResultSrc 10, PCPlus4M 0x104, RdM 0 -> ResultW 0x104, RegWriteW 0.
REQ-039 SHALL test StallW 1 for 3 cycles with changing M inputs -> W outputs constant; FlushW and StallW together -> ValidW 0 next cycle.
REQ-040 SHALL test rst low for 1 edge while StallW 1 with a valid load held -> all outputs 0; with the macro, RetireCountW 0.
REQ-041 SHALL test with the macro: RetireCountW preloaded to 0xFFFF_FFFE, two unstalled valid retirements -> 0xFFFF_FFFF, then 0x0000_0000.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: result-select codes and load funct3 codes.
// Used by the writeback stage and its load extender.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_type_e;

  localparam logic [2:0] F3_LB  = LD_LB;
  localparam logic [2:0] F3_LH  = LD_LH;
  localparam logic [2:0] F3_LW  = LD_LW;
  localparam logic [2:0] F3_LBU = LD_LBU;
  localparam logic [2:0] F3_LHU = LD_LHU;

endpackage

// File: rtl/writeback_stage_if.sv
// M-to-W pipeline bundle: M-stage fields in, register-file write port and status out.
// master drives the M fields; slave is the writeback stage.
interface writeback_stage_if #(
  parameter int WIDTH = 32
);
  logic             ValidM;
  logic             RegWriteM;
  logic [1:0]       ResultSrcM;
  logic [2:0]       LoadTypeM;
  logic [WIDTH-1:0] ALUResultM;
  logic [WIDTH-1:0] ReadDataM;
  logic [WIDTH-1:0] PCPlus4M;
  logic [4:0]       RdM;

  logic             RegWriteW;
  logic [4:0]       RdW;
  logic [WIDTH-1:0] ResultW;
  logic             ValidW;
  logic             MisalignW;

  modport master (
    output ValidM, RegWriteM, ResultSrcM, LoadTypeM, ALUResultM, ReadDataM, PCPlus4M, RdM,
    input  RegWriteW, RdW, ResultW, ValidW, MisalignW
  );

  modport slave (
    input  ValidM, RegWriteM, ResultSrcM, LoadTypeM, ALUResultM, ReadDataM, PCPlus4M, RdM,
    output RegWriteW, RdW, ResultW, ValidW, MisalignW
  );

endinterface

// File: rtl/writeback_stage_load_extend.sv
// Load lane select, sign/zero extension and misalignment detect; purely combinational.
// Misaligned accesses return zero so nothing stale reaches the forwarding path.
module load_extend
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       addr,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] data,
  output logic             misalign
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data     = rdata;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{(WIDTH-8){byte_lane[7]}}, byte_lane};
      F3_LBU: data = {{(WIDTH-8){1'b0}}, byte_lane};
      F3_LH: begin
        misalign = addr[0];
        data     = {{(WIDTH-16){half_lane[15]}}, half_lane};
      end
      F3_LHU: begin
        misalign = addr[0];
        data     = {{(WIDTH-16){1'b0}}, half_lane};
      end
      // LW and every unassigned code behave as a full word
      default: misalign = (addr != 2'b00);
    endcase
    if (misalign) data = '0;
  end

endmodule

// File: rtl/writeback_stage.sv
// M/W pipeline register, result mux and reg-file write gating; 1-cycle M->W, StallW holds, FlushW bubbles.
// Define WRITEBACK_RETIRE_CNT_EN to add the 32-bit RetireCountW retirement counter.
module writeback_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallW,
  input  logic              FlushW,
  writeback_stage_if.slave  wb
`ifdef WRITEBACK_RETIRE_CNT_EN
  ,
  output logic [31:0]       RetireCountW
`endif
);

  logic             valid_q;
  logic             regwrite_q;
  result_src_e      src_q;
  logic [2:0]       ltype_q;
  logic [WIDTH-1:0] alu_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] pc4_q;
  logic [4:0]       rd_q;

  logic [WIDTH-1:0] load_data;
  logic             load_mis;
  logic [WIDTH-1:0] result;
  logic             misalign_w;

  // Flush only kills valid/regwrite; the payload fields are don't-care in a bubble
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= RES_ALU;
      ltype_q    <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      rd_q       <= '0;
    end else if (FlushW) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (!StallW) begin
      valid_q    <= wb.ValidM;
      regwrite_q <= wb.RegWriteM;
      src_q      <= result_src_e'(wb.ResultSrcM);
      ltype_q    <= wb.LoadTypeM;
      alu_q      <= wb.ALUResultM;
      rdata_q    <= wb.ReadDataM;
      pc4_q      <= wb.PCPlus4M;
      rd_q       <= wb.RdM;
    end
  end

  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .addr     (alu_q[1:0]),
    .funct3   (ltype_q),
    .rdata    (rdata_q),
    .data     (load_data),
    .misalign (load_mis)
  );

  always_comb begin
    result = alu_q;
    case (src_q)
      RES_LOAD: result = load_data;
      RES_PC4:  result = pc4_q;
      default:  result = alu_q;
    endcase
  end

  assign misalign_w   = valid_q & (src_q == RES_LOAD) & load_mis;

  assign wb.ValidW    = valid_q;
  assign wb.RdW       = rd_q;
  assign wb.ResultW   = result;
  assign wb.MisalignW = misalign_w;
  assign wb.RegWriteW = regwrite_q & valid_q & (rd_q != 5'd0) & ~misalign_w;

`ifdef WRITEBACK_RETIRE_CNT_EN
  logic [31:0] retire_cnt;

  // Misaligned loads still leave the pipe, so they count as retired
  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_cnt <= '0;
    end else if (valid_q && !StallW) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign RetireCountW = retire_cnt;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed plus randomised bench for writeback_stage with a queue of expected W-stage results.
module tb_writeback_stage;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic StallW = 1'b0;
  logic FlushW = 1'b0;

  always #5 clk = ~clk;

  writeback_stage_if #(.WIDTH(32)) wb ();

`ifdef WRITEBACK_RETIRE_CNT_EN
  logic [31:0] RetireCountW;
`endif

  writeback_stage #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .StallW       (StallW),
    .FlushW       (FlushW),
    .wb           (wb)
`ifdef WRITEBACK_RETIRE_CNT_EN
    ,
    .RetireCountW (RetireCountW)
`endif
  );

  typedef struct {
    string       tag;
    logic        full;
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4,
                       input logic [4:0] rd);
    wb.ValidM     = v;
    wb.RegWriteM  = rw;
    wb.ResultSrcM = src;
    wb.LoadTypeM  = lt;
    wb.ALUResultM = alu;
    wb.ReadDataM  = rdata;
    wb.PCPlus4M   = pc4;
    wb.RdM        = rd;
  endtask

  task automatic expect_w(input string tag, input logic full, input logic v, input logic rw,
                          input logic [4:0] rd, input logic [31:0] res, input logic mis);
    exp_t e;
    e.tag = tag; e.full = full; e.v = v; e.rw = rw; e.rd = rd; e.res = res; e.mis = mis;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare W outputs against the oldest queued expectation
  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_valid"},    {31'd0, wb.ValidW},    {31'd0, e.v});
      check({e.tag, "_regwrite"}, {31'd0, wb.RegWriteW}, {31'd0, e.rw});
      check({e.tag, "_misalign"}, {31'd0, wb.MisalignW}, {31'd0, e.mis});
      if (e.full) begin
        check({e.tag, "_rd"},     {27'd0, wb.RdW},       {27'd0, e.rd});
        check({e.tag, "_result"}, wb.ResultW,            e.res);
      end
    end
  endtask

  // Reference load behaviour: returns {misalign, value}
  function automatic logic [32:0] ref_load(input logic [2:0] lt, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> (8 * a[1:0]);
    case (lt)
      3'b000:  return {1'b0, {24{sh[7]}}, sh[7:0]};
      3'b100:  return {1'b0, 24'd0, sh[7:0]};
      3'b001:  return a[0] ? {1'b1, 32'd0} : {1'b0, {16{sh[15]}}, sh[15:0]};
      3'b101:  return a[0] ? {1'b1, 32'd0} : {1'b0, 16'd0, sh[15:0]};
      default: return (a[1:0] != 2'b00) ? {1'b1, 32'd0} : {1'b0, d};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  lt;
    logic [1:0]  src;
    logic [31:0] a, d, p;
    logic [4:0]  rd;
    logic        rw, v, mis;
    logic [32:0] r;
    logic [31:0] res;

    // Reset with a valid instruction presented on M
    rst = 1'b0;
    drive(1'b1, 1'b1, 2'b01, 3'b010, 32'h40, 32'hAAAA_5555, 32'h44, 5'd4);
    expect_w("reset", 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick_check();
`ifdef WRITEBACK_RETIRE_CNT_EN
    check("reset_count", RetireCountW, 32'd0);
`endif
    rst = 1'b1;

    drive(1'b1, 1'b1, 2'b01, 3'b000, 32'h1003, 32'h80FF_1234, 32'h0, 5'd5);
    expect_w("lb", 1'b1, 1'b1, 1'b1, 5'd5, 32'hFFFF_FF80, 1'b0);
    tick_check();

    drive(1'b1, 1'b1, 2'b01, 3'b101, 32'h2002, 32'hBEEF_0000, 32'h0, 5'd6);
    expect_w("lhu", 1'b1, 1'b1, 1'b1, 5'd6, 32'h0000_BEEF, 1'b0);
    tick_check();

    drive(1'b1, 1'b1, 2'b01, 3'b001, 32'h2001, 32'hBEEF_0000, 32'h0, 5'd7);
    expect_w("lh_misalign", 1'b1, 1'b1, 1'b0, 5'd7, 32'd0, 1'b1);
    tick_check();

    drive(1'b1, 1'b1, 2'b10, 3'b000, 32'h55, 32'h0, 32'h104, 5'd0);
    expect_w("x0_pc4", 1'b1, 1'b1, 1'b0, 5'd0, 32'h104, 1'b0);
    tick_check();

    drive(1'b1, 1'b1, 2'b11, 3'b000, 32'hDEAD_BEEF, 32'h1, 32'h2, 5'd9);
    expect_w("src_rsvd", 1'b1, 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0);
    tick_check();

    // Unaligned address on a non-load, then a misaligned load that is a bubble
    drive(1'b1, 1'b1, 2'b00, 3'b010, 32'h0000_0002, 32'h0, 32'h0, 5'd8);
    expect_w("alu_unaligned", 1'b1, 1'b1, 1'b1, 5'd8, 32'h2, 1'b0);
    tick_check();

    drive(1'b0, 1'b1, 2'b01, 3'b001, 32'h0000_0001, 32'h0, 32'h0, 5'd8);
    expect_w("bubble_load", 1'b0, 1'b0, 1'b0, 5'd8, 32'd0, 1'b0);
    tick_check();

    for (int i = 0; i < 24; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      rw  = 1'($urandom_range(0, 1));
      src = 2'($urandom_range(0, 3));
      lt  = 3'($urandom_range(0, 7));
      a   = $urandom;
      d   = $urandom;
      p   = $urandom;
      rd  = 5'($urandom_range(0, 31));
      drive(v, rw, src, lt, a, d, p, rd);
      r   = ref_load(lt, a, d);
      mis = 1'b0;
      if (src == 2'b01) begin
        res = r[31:0];
        mis = r[32];
      end else if (src == 2'b10) begin
        res = p;
      end else begin
        res = a;
      end
      if (v) expect_w("random", 1'b1, 1'b1, rw && (rd != 5'd0) && !mis, rd, res, mis);
      else   expect_w("random_bubble", 1'b0, 1'b0, 1'b0, rd, res, 1'b0);
      tick_check();
    end

    // Stall holds W while M keeps changing
    drive(1'b1, 1'b1, 2'b01, 3'b100, 32'h31, 32'h0000_AB00, 32'h0, 5'd12);
    expect_w("lbu_pre_stall", 1'b1, 1'b1, 1'b1, 5'd12, 32'h0000_00AB, 1'b0);
    tick_check();
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'b00, 3'b010, $urandom, $urandom, $urandom, 5'(i + 20));
      expect_w("stall_hold", 1'b1, 1'b1, 1'b1, 5'd12, 32'h0000_00AB, 1'b0);
      tick_check();
    end
    FlushW = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 3'b010, 32'h7, 32'h0, 32'h0, 5'd13);
    expect_w("flush_over_stall", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick_check();
    FlushW = 1'b0;
    StallW = 1'b0;

    // Reset arriving while a valid load is held by a stall
    drive(1'b1, 1'b1, 2'b01, 3'b010, 32'h10, 32'h1234_5678, 32'h0, 5'd3);
    expect_w("lw_pre_rst", 1'b1, 1'b1, 1'b1, 5'd3, 32'h1234_5678, 1'b0);
    tick_check();
    StallW = 1'b1;
    drive(1'b1, 1'b1, 2'b01, 3'b010, 32'h20, 32'h0BAD_F00D, 32'h0, 5'd4);
    expect_w("lw_stalled", 1'b1, 1'b1, 1'b1, 5'd3, 32'h1234_5678, 1'b0);
    tick_check();
    rst = 1'b0;
    expect_w("rst_mid_stall", 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick_check();
`ifdef WRITEBACK_RETIRE_CNT_EN
    check("rst_mid_stall_count", RetireCountW, 32'd0);
`endif
    rst = 1'b1;
    expect_w("post_rst_stall", 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick_check();
    StallW = 1'b0;

`ifdef WRITEBACK_RETIRE_CNT_EN
    // Counter wrap: W is a bubble here, so the first edge does not count
    force dut.retire_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.retire_cnt;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0, 5'd1);
    expect_w("cnt_a", 1'b1, 1'b1, 1'b1, 5'd1, 32'h1, 1'b0);
    tick_check();
    check("count_preload", RetireCountW, 32'hFFFF_FFFE);
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h2, 32'h0, 32'h0, 5'd2);
    expect_w("cnt_b", 1'b1, 1'b1, 1'b1, 5'd2, 32'h2, 1'b0);
    tick_check();
    check("count_max", RetireCountW, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h3, 32'h0, 32'h0, 5'd3);
    expect_w("cnt_c", 1'b1, 1'b1, 1'b1, 5'd3, 32'h3, 1'b0);
    tick_check();
    check("count_wrap", RetireCountW, 32'h0000_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
